// File: rtl/RgbdVoConfigPk.sv
// Shared RGB-D VO configuration: image/depth field widths and the packed
// correspondence record passed from the depth-check stage to the pose solver.
package RgbdVoConfigPk;

  localparam int H_SIZE_BW     = 10;
  localparam int V_SIZE_BW     = 9;
  localparam int DATA_DEPTH_BW = 16;

  localparam int CORR_BW = 2 * H_SIZE_BW + 2 * V_SIZE_BW + 2 * DATA_DEPTH_BW;

  typedef struct packed {
    logic [H_SIZE_BW-1:0]     idx0_x;
    logic [V_SIZE_BW-1:0]     idx0_y;
    logic [H_SIZE_BW-1:0]     idx1_x;
    logic [V_SIZE_BW-1:0]     idx1_y;
    logic [DATA_DEPTH_BW-1:0] depth0;
    logic [DATA_DEPTH_BW-1:0] depth1;
  } corr_t;

endpackage

// File: rtl/corr_sync_fifo.sv
// Register-based synchronous FIFO with flush. A push into a full FIFO is
// accepted when a pop happens in the same cycle; the head is read from storage.
module corr_sync_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             pop_ok;
  logic             push_ok;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is data only; pointers alone define occupancy.
  always_ff @(posedge i_clk) begin
    if (push_ok && !i_flush) mem[wr_ptr_q[AW-1:0]] <= i_data;
  end

  assign o_data = o_empty ? '0 : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/corresp_collect.sv
// Compacts valid correspondences into a FIFO for the pose solver and reports
// the per-frame count once drained. CORR_COLLECT_SUBSAMPLE_EN enables r_skip.
module corresp_collect
  import RgbdVoConfigPk::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_BW     = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_frame_start,
  input  logic                     i_frame_end,
  input  logic                     i_valid,
  input  logic [H_SIZE_BW-1:0]     i_idx0_x,
  input  logic [V_SIZE_BW-1:0]     i_idx0_y,
  input  logic [H_SIZE_BW-1:0]     i_idx1_x,
  input  logic [V_SIZE_BW-1:0]     i_idx1_y,
  input  logic [DATA_DEPTH_BW-1:0] i_depth0,
  input  logic [DATA_DEPTH_BW-1:0] i_depth1,
  input  logic [3:0]               r_skip,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [CORR_BW-1:0]       o_corr,
  output logic                     o_frame_done,
  output logic [CNT_BW-1:0]        o_corr_cnt,
  output logic                     o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic [CNT_BW-1:0] sat_inc(input logic [CNT_BW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e state_q, state_d;
  corr_t  in_corr;
  logic   fifo_full, fifo_empty;
  logic   collect_vld;
  logic   keep;
  logic   push_req;
  logic   pop;
  logic   push_ok;

  assign in_corr = '{idx0_x: i_idx0_x, idx0_y: i_idx0_y,
                     idx1_x: i_idx1_x, idx1_y: i_idx1_y,
                     depth0: i_depth0, depth1: i_depth1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_frame_start) begin
      state_d = S_COLLECT;
    end else begin
      unique case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_COLLECT: if (i_frame_end) state_d = S_DRAIN;
        S_DRAIN:   if (fifo_empty) state_d = S_DONE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    collect_vld  = 1'b0;
    o_frame_done = 1'b0;
    unique case (state_q)
      S_COLLECT: collect_vld  = i_valid && !i_frame_start;
      S_DONE:    o_frame_done = 1'b1;
      default:   ;
    endcase
  end

`ifdef CORR_COLLECT_SUBSAMPLE_EN
  logic [3:0] phase_q;

  // Phase steps on every collected valid, kept or not.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           phase_q <= '0;
    else if (i_frame_start) phase_q <= '0;
    else if (collect_vld)   phase_q <= (phase_q == r_skip) ? 4'd0 : phase_q + 4'd1;
  end

  assign keep = (phase_q == 4'd0);
`else
  logic unused_skip;
  assign unused_skip = ^r_skip;
  assign keep        = 1'b1;
`endif

  assign push_req = collect_vld && keep;
  assign pop      = o_valid && i_ready;
  assign push_ok  = push_req && (!fifo_full || pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_corr_cnt <= '0;
      o_overflow <= 1'b0;
    end else if (i_frame_start) begin
      o_corr_cnt <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok)              o_corr_cnt <= sat_inc(o_corr_cnt);
      if (push_req && !push_ok) o_overflow <= 1'b1;
    end
  end

  corr_sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (CORR_BW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_frame_start),
    .i_push  (push_req),
    .i_pop   (pop),
    .i_data  (in_corr),
    .o_data  (o_corr),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_valid = !fifo_empty;

endmodule

// File: tb/tb_corresp_collect.sv
// Directed bench for corresp_collect: table-driven single-frame run plus
// hand-written overflow, full push/pop, frame-end, restart and reset sequences.
module tb_corresp_collect;
  import RgbdVoConfigPk::*;

  localparam int FIFO_DEPTH = 16;
  localparam int CNT_BW     = 20;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n;
  logic                     i_frame_start, i_frame_end, i_valid, i_ready;
  logic [H_SIZE_BW-1:0]     i_idx0_x, i_idx1_x;
  logic [V_SIZE_BW-1:0]     i_idx0_y, i_idx1_y;
  logic [DATA_DEPTH_BW-1:0] i_depth0, i_depth1;
  logic [3:0]               r_skip;
  logic                     o_valid, o_frame_done, o_overflow;
  logic [CORR_BW-1:0]       o_corr;
  logic [CNT_BW-1:0]        o_corr_cnt;

  int checks = 0;
  int errors = 0;

  corresp_collect #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_BW(CNT_BW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .i_valid(i_valid),
    .i_idx0_x(i_idx0_x), .i_idx0_y(i_idx0_y),
    .i_idx1_x(i_idx1_x), .i_idx1_y(i_idx1_y),
    .i_depth0(i_depth0), .i_depth1(i_depth1),
    .r_skip(r_skip),
    .o_valid(o_valid), .i_ready(i_ready), .o_corr(o_corr),
    .o_frame_done(o_frame_done), .o_corr_cnt(o_corr_cnt), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic fs, fe, vld, rdy;
    int   tag;
    logic e_valid;
    int   e_tag;
    logic e_done, e_ovf;
    int   e_cnt;
  } vec_t;

  function automatic corr_t mk(input int tag);
    corr_t c;
    c.idx0_x = H_SIZE_BW'(tag);
    c.idx0_y = V_SIZE_BW'(tag + 1);
    c.idx1_x = H_SIZE_BW'(tag + 2);
    c.idx1_y = V_SIZE_BW'(tag + 3);
    c.depth0 = DATA_DEPTH_BW'(tag + 256);
    c.depth1 = DATA_DEPTH_BW'(tag + 512);
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_corr(input string name, input int tag);
    corr_t e;
    e = mk(tag);
    checks++;
    if (o_corr !== CORR_BW'(e)) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (tag %0d)", name, o_corr, e, tag);
    end
  endtask

  task automatic drive(input logic fs, input logic fe, input logic vld,
                       input logic rdy, input int tag);
    corr_t c;
    c = mk(tag);
    i_frame_start = fs;
    i_frame_end   = fe;
    i_valid       = vld;
    i_ready       = rdy;
    i_idx0_x = c.idx0_x; i_idx0_y = c.idx0_y;
    i_idx1_x = c.idx1_x; i_idx1_y = c.idx1_y;
    i_depth0 = c.depth0; i_depth1 = c.depth1;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Pops n entries, checking each head before it leaves.
  task automatic drain(input string name, input int tag0, input int n, input int stride);
    for (int i = 0; i < n; i++) begin
      chk({name, "_vld"}, o_valid, 1);
      chk_corr({name, "_data"}, tag0 + i * stride);
      drive(0, 0, 0, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic expect_done(input string name, input int cnt);
    chk({name, "_empty"}, o_valid, 0);
    chk({name, "_nodone"}, o_frame_done, 0);
    step();
    chk({name, "_done"}, o_frame_done, 1);
    chk({name, "_cnt"}, o_corr_cnt, 64'(cnt));
    step();
    chk({name, "_done_fall"}, o_frame_done, 0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1,0,0,1,  0, 0, 0, 0,0, 0};
    vecs[1]  = '{0,0,1,1,  1, 1, 1, 0,0, 1};
    vecs[2]  = '{0,0,1,1,  2, 1, 2, 0,0, 2};
    vecs[3]  = '{0,0,1,1,  3, 1, 3, 0,0, 3};
    vecs[4]  = '{0,0,1,1,  4, 1, 4, 0,0, 4};
    vecs[5]  = '{0,0,1,1,  5, 1, 5, 0,0, 5};
    vecs[6]  = '{0,1,0,1,  0, 0, 0, 0,0, 5};
    vecs[7]  = '{0,0,0,1,  0, 0, 0, 1,0, 5};
    vecs[8]  = '{0,0,0,1,  0, 0, 0, 0,0, 5};
    vecs[9]  = '{0,1,1,1,  9, 0, 0, 0,0, 5};
    vecs[10] = '{0,0,0,1,  0, 0, 0, 0,0, 5};

    r_skip  = 4'd0;
    i_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_cnt", o_corr_cnt, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_corr", o_corr, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;

    // Basic frame: five entries, each visible one cycle after its push.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].fs, vecs[i].fe, vecs[i].vld, vecs[i].rdy, vecs[i].tag);
      step();
      chk($sformatf("v%0d_valid", i), o_valid, 64'(vecs[i].e_valid));
      chk($sformatf("v%0d_done", i), o_frame_done, 64'(vecs[i].e_done));
      chk($sformatf("v%0d_ovf", i), o_overflow, 64'(vecs[i].e_ovf));
      chk($sformatf("v%0d_cnt", i), o_corr_cnt, 64'(vecs[i].e_cnt));
      if (vecs[i].e_valid) chk_corr($sformatf("v%0d_corr", i), vecs[i].e_tag);
    end

    // Overflow: 20 pushes with ready low keep the first 16.
    drive(1, 0, 0, 0, 0); step();
    for (int i = 0; i < 20; i++) begin drive(0, 0, 1, 0, 100 + i); step(); end
    drive(0, 0, 0, 0, 0);
    chk("ovf_cnt", o_corr_cnt, 16);
    chk("ovf_flag", o_overflow, 1);
    drive(0, 1, 0, 0, 0); step();
    drain("ovf", 100, 16, 1);
    expect_done("ovf", 16);
    chk("ovf_sticky", o_overflow, 1);

    // Full FIFO with simultaneous pop accepts the push.
    drive(1, 0, 0, 0, 0); step();
    chk("full_start_ovf", o_overflow, 0);
    chk("full_start_cnt", o_corr_cnt, 0);
    for (int i = 0; i < 16; i++) begin drive(0, 0, 1, 0, 200 + i); step(); end
    chk("full_cnt16", o_corr_cnt, 16);
    drive(0, 0, 1, 1, 216); step();
    chk("full_pp_ovf", o_overflow, 0);
    chk("full_pp_cnt", o_corr_cnt, 17);
    drive(0, 1, 0, 0, 0); step();
    drain("full", 201, 16, 1);
    expect_done("full", 17);

    // Valid coincident with frame end is kept; later valids are ignored.
    drive(1, 0, 0, 0, 0); step();
    drive(0, 1, 1, 0, 300); step();
    chk("fe_cnt", o_corr_cnt, 1);
    drive(0, 0, 1, 0, 301); step();
    chk("fe_drain_cnt", o_corr_cnt, 1);
    drain("fe", 300, 1, 1);
    expect_done("fe", 1);

    // Frame start during DRAIN flushes and restarts collection.
    drive(1, 0, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0, 400 + i); step(); end
    drive(0, 1, 0, 0, 0); step();
    chk("rs_queued", o_corr_cnt, 3);
    drive(1, 0, 0, 0, 0); step();
    chk("rs_valid", o_valid, 0);
    chk("rs_cnt", o_corr_cnt, 0);
    chk("rs_ovf", o_overflow, 0);
    chk("rs_done", o_frame_done, 0);
    drive(0, 0, 1, 0, 410); step();
    chk("rs_collect_valid", o_valid, 1);
    chk_corr("rs_collect_corr", 410);
    chk("rs_collect_cnt", o_corr_cnt, 1);
    drive(0, 0, 0, 0, 0); step();
    chk("rs_nodone", o_frame_done, 0);
    drive(0, 1, 0, 0, 0); step();
    drain("rs", 410, 1, 1);
    expect_done("rs", 1);

`ifdef CORR_COLLECT_SUBSAMPLE_EN
    r_skip = 4'd3;
    drive(1, 0, 0, 0, 0); step();
    for (int i = 0; i < 12; i++) begin drive(0, 0, 1, 0, 500 + i); step(); end
    chk("sub_cnt", o_corr_cnt, 3);
    drive(0, 1, 0, 0, 0); step();
    drain("sub", 500, 3, 4);
    expect_done("sub", 3);
    r_skip = 4'd0;
`endif

    // Asynchronous reset mid-frame.
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 600); step();
    drive(0, 0, 1, 0, 601); step();
    drive(0, 0, 0, 0, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_cnt", o_corr_cnt, 0);
    chk("arst_ovf", o_overflow, 0);
    chk("arst_done", o_frame_done, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(0, 0, 1, 0, 602); step();
    chk("arst_idle_valid", o_valid, 0);
    chk("arst_idle_cnt", o_corr_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
